alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_rr_arbiter_if.sv | 45 ++++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: default width, opcodes
// and arbiter FSM states.
package alu_pkg;

    localparam int unsigned W_DEF = 4;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_EQU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bus between two requesters, one result consumer and the ALU arbiter.
// slave  : arbiter side (takes requests, drives readies and the response)
// master : requester/consumer side
interface alu_rr_arbiter_if #(
    parameter int unsigned W = alu_pkg::W_DEF
);
    localparam int unsigned OP_W = alu_pkg::OP_W;

    logic            req0_valid;
    logic            req0_ready;
    logic [W-1:0]    req0_a;
    logic [W-1:0]    req0_b;
    logic [OP_W-1:0] req0_op;

    logic            req1_valid;
    logic            req1_ready;
    logic [W-1:0]    req1_a;
    logic [W-1:0]    req1_b;
    logic [OP_W-1:0] req1_op;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [W-1:0]    rsp_s;
    logic            rsp_z;
    logic            rsp_o;
    logic            rsp_c;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_s, rsp_z, rsp_o, rsp_c,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_s, rsp_z, rsp_o, rsp_c,
        output rsp_ready
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU.
// Ports: a, b (operands), op (opcode) -> s (result), z/o/c (zero, overflow, carry).
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] s,
    output logic         z,
    output logic         o,
    output logic         c
);

    logic [W:0] sum;

    // Result and flags; logic and compare ops leave o/c at zero
    always_comb begin
        sum = '0;
        s   = '0;
        o   = 1'b0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                s   = sum[W-1:0];
                c   = sum[W];
                o   = (s[W-1] ^ a[W-1]) & ~(a[W-1] ^ b[W-1]);
            end
            OP_SUB: begin
                // carry is the inverted borrow of a + ~b + 1
                sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                s   = sum[W-1:0];
                c   = sum[W];
                o   = (s[W-1] ^ a[W-1]) & (a[W-1] ^ b[W-1]);
            end
            OP_NOT:  s = ~a;
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            OP_XOR:  s = a ^ b;
            OP_SLT:  s = W'($signed(a) < $signed(b));
            OP_EQU:  s = W'(a == b);
            default: s = '0;
        endcase
        z = (s == '0);
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport carrying
// both request channels, the grant readies and the registered response).
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rr_arbiter_if.slave   bus
);

    arb_state_e   state;
    arb_state_e   state_nxt;
    logic         ptr;
    logic         grant_c;
    logic         grant_id_c;

    logic [W-1:0] lat_a;
    logic [W-1:0] lat_b;
    alu_op_e      lat_op;
    logic         lat_id;

    logic [W-1:0] alu_s;
    logic         alu_z;
    logic         alu_o;
    logic         alu_c;

    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_s;
    logic         rsp_z;
    logic         rsp_o;
    logic         rsp_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant; rst_n gates the grant so readies stay low in reset
    always_comb begin
        state_nxt  = state;
        grant_c    = 1'b0;
        grant_id_c = ptr;
        case (state)
            ST_IDLE: begin
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    grant_c = 1'b1;
                    // contention goes to the pointer, a lone requester wins outright
                    if (bus.req0_valid && bus.req1_valid) begin
                        grant_id_c = ptr;
                    end else begin
                        grant_id_c = bus.req1_valid;
                    end
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Readies are the same-cycle grant
    assign bus.req0_ready = grant_c && !grant_id_c;
    assign bus.req1_ready = grant_c &&  grant_id_c;

    // Operand latch, round-robin pointer and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_op    <= OP_ADD;
            lat_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= '0;
            rsp_z     <= 1'b0;
            rsp_o     <= 1'b0;
            rsp_c     <= 1'b0;
        end else begin
            if (grant_c) begin
                ptr    <= ~grant_id_c;
                lat_id <= grant_id_c;
                lat_a  <= grant_id_c ? bus.req1_a : bus.req0_a;
                lat_b  <= grant_id_c ? bus.req1_b : bus.req0_b;
                lat_op <= alu_op_e'(grant_id_c ? bus.req1_op : bus.req0_op);
            end
            if (state == ST_EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= lat_id;
                rsp_s     <= alu_s;
                rsp_z     <= alu_z;
                rsp_o     <= alu_o;
                rsp_c     <= alu_c;
            end else if ((state == ST_RESP) && bus.rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    alu_core #(.W(W)) u_alu_core (
        .a  (lat_a),
        .b  (lat_b),
        .op (lat_op),
        .s  (alu_s),
        .z  (alu_z),
        .o  (alu_o),
        .c  (alu_c)
    );

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_s     = rsp_s;
    assign bus.rsp_z     = rsp_z;
    assign bus.rsp_o     = rsp_o;
    assign bus.rsp_c     = rsp_c;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed vectors with literal
// expectations plus a transaction-level model compared every cycle.
module tb_alu_rr_arbiter;

    localparam int unsigned W = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.W(W)) bus ();

    alu_rr_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s;
        int z;
        int o;
        int c;
        int id;
    } rsp_t;

    typedef struct {
        int a;
        int b;
        int op;
        int s;
        int z;
        int o;
        int c;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v > SMAX) ? v - (1 << W) : v;
    endfunction

    // Expected result from plain integer arithmetic
    function automatic rsp_t model(input int a, input int b, input int op, input int id);
        rsp_t m;
        int sa;
        int sb;
        int r;
        sa   = to_signed(a);
        sb   = to_signed(b);
        m.id = id;
        m.o  = 0;
        m.c  = 0;
        m.s  = 0;
        case (op)
            0: begin
                r   = a + b;
                m.s = r & MASK;
                m.c = (r > MASK) ? 1 : 0;
                m.o = ((sa + sb) > SMAX || (sa + sb) < SMIN) ? 1 : 0;
            end
            1: begin
                r   = a - b;
                m.s = r & MASK;
                m.c = (a >= b) ? 1 : 0;
                m.o = ((sa - sb) > SMAX || (sa - sb) < SMIN) ? 1 : 0;
            end
            2: m.s = (~a) & MASK;
            3: m.s = a & b;
            4: m.s = a | b;
            5: m.s = a ^ b;
            6: m.s = (sa < sb) ? 1 : 0;
            default: m.s = (a == b) ? 1 : 0;
        endcase
        m.z = (m.s == 0) ? 1 : 0;
        return m;
    endfunction

    // Transaction-level model: at most one operation in flight, response due
    // two edges after its grant, round-robin pointer toggled away from the winner
    bit   m_busy = 1'b0;
    int   m_age = 0;
    bit   m_ptr = 1'b0;
    int   m_g;
    rsp_t m_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req0_ready", bus.req0_ready, 0);
            chk("rst_req1_ready", bus.req1_ready, 0);
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            m_g = -1;
            if (!m_busy) begin
                if (bus.req0_valid && bus.req1_valid) m_g = int'(m_ptr);
                else if (bus.req0_valid)              m_g = 0;
                else if (bus.req1_valid)              m_g = 1;
            end
            chk("m_req0_ready", bus.req0_ready, (m_g == 0) ? 1 : 0);
            chk("m_req1_ready", bus.req1_ready, (m_g == 1) ? 1 : 0);
            if (m_busy && m_age >= 2) begin
                chk("m_rsp_valid", bus.rsp_valid, 1);
                chk("m_rsp_s", bus.rsp_s, m_exp.s);
                chk("m_rsp_z", bus.rsp_z, m_exp.z);
                chk("m_rsp_o", bus.rsp_o, m_exp.o);
                chk("m_rsp_c", bus.rsp_c, m_exp.c);
                chk("m_rsp_id", bus.rsp_id, m_exp.id);
                if (bus.rsp_ready) m_busy = 1'b0;
                else               m_age++;
            end else begin
                chk("m_rsp_valid_low", bus.rsp_valid, 0);
                if (m_busy) m_age++;
            end
            if (m_g == 0) begin
                m_exp  = model(int'(bus.req0_a), int'(bus.req0_b), int'(bus.req0_op), 0);
                m_busy = 1'b1;
                m_age  = 1;
                m_ptr  = 1'b1;
            end else if (m_g == 1) begin
                m_exp  = model(int'(bus.req1_a), int'(bus.req1_b), int'(bus.req1_op), 1);
                m_busy = 1'b1;
                m_age  = 1;
                m_ptr  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid, wait (bounded) for the grant, drop valid after the grant edge
    task automatic send(input int n, input int a, input int b, input int op);
        bit got;
        got = 1'b0;
        if (n == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a[W-1:0];
            bus.req0_b     = b[W-1:0];
            bus.req0_op    = op[2:0];
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a[W-1:0];
            bus.req1_b     = b[W-1:0];
            bus.req1_op    = op[2:0];
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? bus.req0_ready : bus.req1_ready;
        end
        chk($sformatf("grant%0d", n), got, 1);
        tick();
        if (n == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    // Wait (bounded) for a response and compare with literal expectations
    task automatic expect_rsp(input string name, input int s, input int z, input int o,
                              input int c, input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        chk({name, "_valid"}, seen, 1);
        if (seen) begin
            chk({name, "_s"}, bus.rsp_s, s);
            chk({name, "_z"}, bus.rsp_z, z);
            chk({name, "_o"}, bus.rsp_o, o);
            chk({name, "_c"}, bus.rsp_c, c);
            chk({name, "_id"}, bus.rsp_id, id);
        end
        tick();
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{8, 1, 1, 7, 0, 1, 1};
        vecs[1] = '{5, 0, 2, 10, 0, 0, 0};
        vecs[2] = '{9, 3, 3, 1, 0, 0, 0};
        vecs[3] = '{9, 3, 4, 11, 0, 0, 0};
        vecs[4] = '{9, 3, 5, 10, 0, 0, 0};
        vecs[5] = '{6, 7, 6, 1, 0, 0, 0};
        vecs[6] = '{7, 6, 6, 0, 1, 0, 0};
        vecs[7] = '{15, 15, 0, 14, 0, 0, 1};
        vecs[8] = '{7, 6, 7, 0, 1, 0, 0};

        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_op    = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_op    = '0;
        bus.rsp_ready  = 1'b1;
        rst_n          = 1'b0;

        // Reset values
        tick();
        tick();
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_s", bus.rsp_s, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_flags", {bus.rsp_z, bus.rsp_o, bus.rsp_c}, 0);
        tick();
        rst_n = 1'b1;

        // Lone req0 add with signed overflow
        fork
            send(0, 7, 1, 0);
            expect_rsp("add_ovf", 8, 0, 1, 0, 0);
        join

        // Contention right after reset: req0 first, then req1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fork
            send(0, 3, 3, 1);
            send(1, 10, 5, 5);
            begin
                expect_rsp("sub_eq", 0, 1, 0, 1, 0);
                expect_rsp("xor", 15, 0, 0, 0, 1);
            end
        join

        // Signed compare and equality
        fork
            send(1, 8, 7, 6);
            expect_rsp("slt", 1, 0, 0, 0, 1);
        join
        fork
            send(1, 5, 5, 7);
            expect_rsp("equ", 1, 0, 0, 0, 1);
        join

        // Backpressure: three cycles with rsp_ready low, req1 waiting meanwhile
        bus.rsp_ready = 1'b0;
        fork
            send(0, 12, 10, 3);
            begin : bp
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 30 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus.rsp_valid;
                end
                chk("bp_valid", seen, 1);
                chk("bp_s", bus.rsp_s, 8);
                chk("bp_id", bus.rsp_id, 0);
                tick();
                bus.req1_valid = 1'b1;
                bus.req1_a     = 4'hF;
                bus.req1_b     = 4'h1;
                bus.req1_op    = 3'b000;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    chk("bp_hold_valid", bus.rsp_valid, 1);
                    chk("bp_hold_s", bus.rsp_s, 8);
                    chk("bp_hold_ready1", bus.req1_ready, 0);
                    tick();
                end
                bus.rsp_ready = 1'b1;
                @(negedge clk);
                chk("bp_release_valid", bus.rsp_valid, 1);
                tick();
                @(negedge clk);
                chk("bp_after_valid", bus.rsp_valid, 0);
                chk("bp_after_ready1", bus.req1_ready, 1);
                tick();
                bus.req1_valid = 1'b0;
                expect_rsp("bp_add", 0, 1, 0, 1, 1);
            end
        join

        // Reset while req0's operation is executing
        send(0, 3, 4, 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("killed_no_rsp", bus.rsp_valid, 0);
        end
        tick();
        fork
            send(0, 0, 1, 1);
            send(1, 7, 7, 0);
            begin
                expect_rsp("post_rst_sub", 15, 0, 0, 0, 0);
                expect_rsp("post_rst_add", 14, 0, 1, 0, 1);
            end
        join

        // Operation table, alternating requesters
        for (int i = 0; i < 9; i++) begin
            fork
                send(i % 2, vecs[i].a, vecs[i].b, vecs[i].op);
                expect_rsp($sformatf("vec%0d", i), vecs[i].s, vecs[i].z, vecs[i].o,
                           vecs[i].c, i % 2);
            join
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
